uart_tx_frame: RTL and testbench

Parametrised UART transmit framer, the successor to the fixed start/data/parity/stop select mux. It accepts a DATA_W-bit word over a valid/ready handshake and serialises it onto txd as a complete frame: start bit, LSB-first data bits, optional parity bit, then 1 or 2 stop bits. An internal bit timer times every bit. The block sits between the transmit buffer and the pad driver.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_tx_frame.sv | 158 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit framer.
// Holds the frame FSM state encoding, parity mode codes and line idle level.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit period timer: counts 0..CLKS_PER_BIT-1 and flags the final cycle.
// Ports: clk, rst (sync, active-high), clr (restart at 0), bit_end (last cycle of a bit).
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign bit_end = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + TW'(1);
        if (clr || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, 1-2 stop bits.
// Ports: clk, rst, tx_data/tx_valid/tx_ready handshake, parity_mode, txd, busy, tx_done.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [1:0]        parity_mode,
    output logic              txd,
    output logic              busy,
    output logic              tx_done
);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $fatal(1, "uart_tx_frame: DATA_W must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $fatal(1, "uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $fatal(1, "uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              txd_q, txd_d;
    logic              done_q, done_d;
    logic              bit_end;
    logic              idle;

    assign idle = (state_q == IDLE);

    // Held clear while idle so the first bit period starts at the accept edge.
    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (idle),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        txd_d     = txd_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                txd_d = IDLE_LEVEL;
                if (tx_valid) begin
                    state_d  = START;
                    shreg_d  = tx_data;
                    cnt_d    = '0;
                    txd_d    = 1'b0;
                    // Reserved mode 11 behaves as no parity.
                    par_en_d = (parity_mode == PAR_EVEN) ||
                               (parity_mode == PAR_ODD);
                    // Parity captured now, since the shifter loses the word.
                    par_bit_d = (^tx_data) ^ (parity_mode == PAR_ODD);
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    txd_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = CNT_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (cnt_q == DATA_LAST) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = IDLE_LEVEL;
                            cnt_d   = CNT_ONE;
                        end
                    end else begin
                        txd_d   = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = IDLE_LEVEL;
                    cnt_d   = CNT_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (cnt_q == STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = IDLE_LEVEL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            txd_q     <= IDLE_LEVEL;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
        end
    end

    assign txd      = txd_q;
    assign tx_ready = idle;
    assign busy     = !idle;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame (DATA_W=8, CLKS_PER_BIT=4).
// Instance a uses one stop bit, instance b two stop bits.
module tb_uart_tx_frame;

    localparam int DW  = 8;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic [1:0] parity_mode;
    logic       va, vb;
    logic       ra, rb, txa, txb, ba, bb, da, db;
    bit         sel;

    logic s_txd, s_rdy, s_busy, s_done;
    assign s_txd  = sel ? txb : txa;
    assign s_rdy  = sel ? rb  : ra;
    assign s_busy = sel ? bb  : ba;
    assign s_done = sel ? db  : da;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(va),
        .tx_ready(ra), .parity_mode(parity_mode), .txd(txa),
        .busy(ba), .tx_done(da)
    );

    uart_tx_frame #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(vb),
        .tx_ready(rb), .parity_mode(parity_mode), .txd(txb),
        .busy(bb), .tx_done(db)
    );

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  mode;
        bit          inst;
        logic [11:0] exp;   // leftmost of nbits = first bit on the line
        int          nbits;
    } vec_t;

    vec_t tbl[7];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int idx,
                       input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %b want %b", name, idx, act, req);
        end
    endtask

    task automatic set_valid(input bit inst, input logic v);
        if (inst) vb = v;
        else va = v;
    endtask

    task automatic send(input vec_t v);
        bit ok = 0;
        sel = v.inst;
        @(negedge clk);
        tx_data     = v.data;
        parity_mode = v.mode;
        set_valid(v.inst, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (s_rdy) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("accept", 0, ok, 1'b1);
        if (ok) sb.push_back(v);
        else set_valid(v.inst, 1'b0);
    endtask

    // Call right after the accept edge; finishes at the tx_done sample.
    task automatic check_frame(input bit drop, input logic [7:0] nd);
        vec_t v;
        int   n;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1'b0, 1'b1);
            return;
        end
        v = sb.pop_front();
        n = v.nbits * CPB;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k < n) begin
                chk("txd", k, s_txd, v.exp[v.nbits - 1 - k / CPB]);
                chk("busy", k, s_busy, 1'b1);
                chk("done", k, s_done, 1'b0);
            end else begin
                chk("end_done", k, s_done, 1'b1);
                chk("end_rdy", k, s_rdy, 1'b1);
                chk("end_txd", k, s_txd, 1'b1);
            end
            if (k == 0) begin
                if (drop) set_valid(v.inst, 1'b0);
                tx_data = nd;
            end
        end
    endtask

    task automatic check_quiet();
        @(negedge clk);
        chk("post_done", 0, s_done, 1'b0);
        chk("post_txd", 0, s_txd, 1'b1);
    endtask

    initial begin
        tbl[0] = '{8'h55, 2'b01, 1'b0, 12'b010101010010, 11};
        tbl[1] = '{8'h55, 2'b10, 1'b0, 12'b010101010110, 11};
        tbl[2] = '{8'hA3, 2'b00, 1'b1, 12'b011000101110, 11};
        tbl[3] = '{8'hA3, 2'b11, 1'b1, 12'b011000101110, 11};
        tbl[4] = '{8'h01, 2'b00, 1'b0, 12'b000100000001, 10};
        tbl[5] = '{8'hFF, 2'b00, 1'b0, 12'b000111111111, 10};
        tbl[6] = '{8'h55, 2'b01, 1'b0, 12'b010101010010, 11};
        // exp is 12 bits wide; shift shorter frames so bit nbits-1 is first.
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].nbits == 11) tbl[i].exp = tbl[i].exp >> 1;
        end

        sel = 0;
        rst = 1'b1;
        va = 1'b1;
        vb = 1'b1;
        tx_data = 8'hC3;
        parity_mode = 2'b01;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                sel = bit'(s);
                #0;
                chk("rst_txd", c, s_txd, 1'b1);
                chk("rst_rdy", c, s_rdy, 1'b1);
                chk("rst_busy", c, s_busy, 1'b0);
                chk("rst_done", c, s_done, 1'b0);
            end
        end
        va = 1'b0;
        vb = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        sel = 0;
        #0;
        chk("idle_rdy", 0, s_rdy, 1'b1);

        for (int i = 0; i < 4; i++) begin
            send(tbl[i]);
            check_frame(1'b1, 8'h00);
            check_quiet();
        end

        // Back-to-back with valid held and data changed mid-frame.
        send(tbl[4]);
        check_frame(1'b0, 8'hFF);
        @(posedge clk);
        sb.push_back(tbl[5]);
        check_frame(1'b1, 8'h00);
        check_quiet();

        // Reset during data bit 3, then a clean frame.
        send(tbl[6]);
        if (sb.size() != 0) void'(sb.pop_front());
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            chk("pre_rst_txd", k, s_txd, tbl[6].exp[10 - k / CPB]);
            if (k == 0) va = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_txd", 0, s_txd, 1'b1);
        chk("mid_rst_rdy", 0, s_rdy, 1'b1);
        chk("mid_rst_busy", 0, s_busy, 1'b0);
        chk("mid_rst_done", 0, s_done, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("after_rst_done", k, s_done, 1'b0);
            chk("after_rst_txd", k, s_txd, 1'b1);
        end
        send(tbl[6]);
        check_frame(1'b1, 8'h00);
        check_quiet();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
